// File: rtl/uart_command_tx_pkg.sv
// Shared constants, state type and message ROM for the UART command sender.
// Imported by the byte serializer and the top-level sequencer.
package uart_cmd_pkg;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BIT_DIV  = CLK_FREQ / BAUD;
    localparam int MSG_LEN  = 4;
    localparam int IDX_W    = $clog2(MSG_LEN);
    localparam int CNT_W    = 9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // "AT\r\n"
    localparam logic [7:0] MSG [MSG_LEN] = '{
        8'h41, 8'h54, 8'h0D, 8'h0A
    };

    function automatic logic [7:0] msg_byte(
        input logic [IDX_W-1:0] idx
    );
        return MSG[idx];
    endfunction

endpackage

// File: rtl/uart_command_tx_if.sv
// Board-level signal bundle: serial line out, trigger in.
// master = trigger source / line observer, slave = transmitter side.
interface uart_command_tx_if;

    logic tx;
    logic command_in;

    modport master (
        output command_in,
        input  tx
    );

    modport slave (
        input  command_in,
        output tx
    );

endinterface

// File: rtl/uart_command_tx_byte.sv
// 8N1 byte serializer with baud counter, LSB first.
// Ports: clk, rst, start, data[7:0] in; tx, busy, done out.
module uart_byte_tx
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the level for the bit that begins at the next edge,
    // so the line changes exactly on the state transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (start) begin
                    state_d = START;
                    sh_d    = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end
            end
            STOP: begin
                // back-to-back bytes: a start here skips IDLE
                if (bit_end) begin
                    if (start) begin
                        state_d = START;
                        sh_d    = data;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == STOP) && bit_end;

endmodule

// File: rtl/uart_command_tx.sv
// Board top: sends "AT\r\n" over 8N1 UART on each rising command_in edge.
// Ports: rst (sync, active-high), clk, tx (serial out), command_in (async trigger).
module uart_command_tx
    import uart_cmd_pkg::*;
(
    input  logic rst,
    input  logic clk,
    output logic tx,
    input  logic command_in
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    logic             sync1, sync2, sync3;
    logic             start_pulse;
    logic             launch, more, start;
    logic             busy, done;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data;

    // if/else keeps an unknown trigger level from ever loading a 1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            idx_q <= '0;
        end else begin
            if (command_in) begin
                sync1 <= 1'b1;
            end else begin
                sync1 <= 1'b0;
            end
            sync2 <= sync1;
            sync3 <= sync2;
            idx_q <= idx_d;
        end
    end

    assign start_pulse = sync2 & ~sync3;

    // busy is still high on the final stop-bit cycle, so an edge there
    // is dropped rather than queued
    assign launch = start_pulse & ~busy;
    assign more   = done && (idx_q != IDX_LAST);
    assign start  = launch | more;

    always_comb begin
        idx_d = idx_q;
        if (launch) begin
            idx_d = '0;
        end else if (more) begin
            idx_d = idx_q + 1'b1;
        end
    end

    assign data = msg_byte(launch ? '0 : idx_q + 1'b1);

    uart_byte_tx u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

endmodule

// File: tb/tb_uart_command_tx.sv
// Scoreboard bench for uart_command_tx: stimulus queues expected bytes,
// a UART line monitor decodes tx and compares frame by frame.
module tb_uart_command_tx;

    localparam int DIV = 434;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_command_tx_if u_if ();

    uart_command_tx dut (
        .rst        (rst),
        .clk        (clk),
        .tx         (u_if.tx),
        .command_in (u_if.command_in)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_msg();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic idle_window(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (u_if.tx !== 1'b1) bad++;
        end
        check(name, bad, 0);
    endtask

    // line monitor: samples on the falling edge, bit centres at 217+434*j
    initial begin
        int mcnt;
        int lowrun;
        int exp_low;
        bit mbusy;
        bit lowdone;
        bit zrun;
        logic [9:0] frame;
        logic [7:0] e;
        mbusy = 0;
        mcnt = 0;
        lowrun = 0;
        lowdone = 0;
        frame = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mbusy = 0;
            end else if (!mbusy) begin
                if (u_if.tx === 1'b0) begin
                    mbusy = 1;
                    mcnt = 0;
                    lowrun = 1;
                    lowdone = 0;
                    frame = '1;
                end
            end else begin
                mcnt++;
                if (!lowdone) begin
                    if (u_if.tx === 1'b0) lowrun++;
                    else lowdone = 1;
                end
                if ((mcnt % DIV) == DIV / 2 && (mcnt / DIV) <= 9)
                    frame[mcnt / DIV] = u_if.tx;
                if (mcnt == DIV / 2 + DIV * 9) begin
                    mbusy = 0;
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {22'd0, frame}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", {22'd0, frame}, {22'd0, 1'b1, e, 1'b0});
                        exp_low = DIV;
                        zrun = 1;
                        for (int i = 0; i < 8; i++) begin
                            if (zrun && e[i] == 1'b0) exp_low += DIV;
                            else zrun = 0;
                        end
                        check("low_run", lowrun, exp_low);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        u_if.command_in = 1'b0;
        rst = 1'b1;

        // 1: reset and long idle, including an unknown trigger level
        idle_window("reset_tx", 5);
        rst = 1'b0;
        u_if.command_in = 1'bx;
        idle_window("x_trigger_idle", 1000);
        u_if.command_in = 1'b0;
        idle_window("post_reset_idle", 9000);
        check("no_bytes_idle", rx_count, 0);

        // 2/3: one 10-cycle pulse, latency to start bit
        base = rx_count;
        @(posedge clk);
        #1 u_if.command_in = 1'b1;
        push_msg();
        @(posedge clk);
        #1 check("lat_k", u_if.tx, 1);
        @(posedge clk);
        #1 check("lat_k1", u_if.tx, 1);
        @(posedge clk);
        #1 check("lat_k2_start", u_if.tx, 0);
        repeat (7) @(posedge clk);
        #1 u_if.command_in = 1'b0;

        // 4: re-trigger while busy must be ignored
        repeat (1990) @(posedge clk);
        #1 u_if.command_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 u_if.command_in = 1'b0;
        repeat (17360 - 2000 - 12) @(posedge clk);
        idle_window("msg1_end_idle", 100);
        check("msg1_bytes", rx_count - base, 4);
        check("msg1_queue", exp_q.size(), 0);

        // 5: reset in the middle of byte 1 then a fresh message
        base = rx_count;
        @(posedge clk);
        #1 u_if.command_in = 1'b1;
        push_msg();
        repeat (10) @(posedge clk);
        #1 u_if.command_in = 1'b0;
        repeat (5990) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 check("reset_abort_tx", u_if.tx, 1);
        check("abort_bytes", rx_count - base, 1);
        rst = 1'b0;
        idle_window("after_abort_idle", 500);

        // 6: trigger held high for a long time gives one message only
        base = rx_count;
        @(posedge clk);
        #1 u_if.command_in = 1'b1;
        push_msg();
        repeat (40000) @(posedge clk);
        #1 check("hold_bytes", rx_count - base, 4);
        check("hold_queue", exp_q.size(), 0);
        check("hold_tx_idle", u_if.tx, 1);
        u_if.command_in = 1'b0;
        idle_window("final_idle", 50);
        check("final_bytes", rx_count - base, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_command_tx.md
Name: uart_command_tx

Overview:
- Top-level UART command transmitter for the digital-communications design.
- A rising edge on `command_in` makes the block transmit a fixed 4-byte ASCII command, "AT\r\n", on the serial line `tx`.
- Frame format: 8N1, LSB first.
- It is the board top: one system clock, one serial output, one trigger input.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz (20 ns period).
- BAUD, 115200, serial bit rate.
- BIT_DIV, CLK_FREQ/BAUD (integer division = 434), clock cycles per serial bit.
- MSG_LEN, 4, number of bytes in the command message.

Ports (positional order is fixed: rst, clk, tx, command_in):
- rst  input  1  synchronous reset, active-high, sampled on rising clk.
- clk  input  1  single system clock; all logic on its rising edge.
- tx  output  1  UART serial output; idles high (mark).
- command_in  input  1  asynchronous trigger; a rising edge starts one message transmission.

Behaviour:
- Reset (rst=1 at a rising edge) drives all of the following to their idle values on that edge:
  - tx=1, state IDLE, byte index 0, bit index 0, baud counter 0.
  - Synchronizer flops cleared to 0.
  - Reset mid-frame aborts the frame; tx=1 from the next edge onward.
- Input conditioning:
  - command_in passes through a 2-flop synchronizer, then a third flop for edge detect.
  - start_pulse = sync2 & ~sync3.
  - A non-1 value (X/Z) must never start a transmission; treat it as 0.
- Latency: with command_in high before clock edge k (edge k is its first sampling edge), tx is registered low at edge k+2 (start bit begins).
- State machine IDLE -> START -> DATA -> STOP -> (START | IDLE):
  - IDLE: tx=1. On start_pulse, load byte index 0 and go to START.
  - START: tx=0 for BIT_DIV cycles.
  - DATA: 8 bits, each held BIT_DIV cycles, LSB first.
  - STOP: tx=1 for BIT_DIV cycles. Then, if byte index < MSG_LEN-1, increment the index and go to START with no idle gap; otherwise go to IDLE.
- Baud counter:
  - 9-bit; counts 0..BIT_DIV-1.
  - Wraps to 0 at the end of each bit and advances the bit/state.
  - Held at 0 in IDLE.
- Message ROM: byte0=0x41, byte1=0x54, byte2=0x0D, byte3=0x0A.
- Frame timing:
  - One frame = 10*BIT_DIV = 4340 cycles.
  - Full message = 17360 cycles (347.2 us).
- Busy rules:
  - start_pulse is ignored in every non-IDLE state.
  - Holding command_in high produces exactly one message; re-arming needs a low then high.
- An edge arriving in the same cycle the FSM returns to IDLE is ignored.
- tx is a registered output (no glitches).

Decomposition:
- Package uart_cmd_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - BIT_DIV and MSG_LEN constants
  - message byte array constant
- One natural sub-module, uart_byte_tx:
  - ports: clk, rst, start, data[7:0], tx, busy, done
  - contains the baud counter and serializer.
- The top holds the synchronizer, edge detect, message sequencer and ROM.

Test Plan:
1. Hold rst=1 for 5 cycles, command_in=0 -> tx=1 throughout, and for 10,000 cycles after release.
2. Pulse command_in high for 10 cycles -> tx low at the 3rd edge after the first high sample. Decoding at 434 cycles/bit mid-bit yields bytes 0x41,0x54,0x0D,0x0A, each with start=0 and stop=1. tx returns idle-high after 17360 cycles.
3. Measure the start-bit low time of 0x41 -> exactly 434 cycles. Then check bit0=1 and bit1=0 at the corresponding bit centres.
4. Pulse command_in again at cycle 2000 of an ongoing message -> no extra bytes; total output still 4 bytes.
5. Assert rst at cycle 6000 (mid byte 1) -> tx=1 from the next edge. A new command_in pulse afterwards sends the full 4-byte message from 0x41.
6. Hold command_in high for 40,000 cycles -> exactly one 4-byte message, then idle high.
